// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch front end.
// Carries the fetch FSM encoding and the buffered {pc, inst} entry.
package ifetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] INST_NOP_END = 32'h0;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_unit_fifo.sv
// Circular fetch buffer between IMEM capture and decode.
// Head is read straight from storage registers, never from the push data.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned PW = $clog2(FIFO_DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t   mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;
  logic           do_pop;
  logic           do_push;
  logic           not_empty;
  logic           not_full;

  assign not_empty = count_q != '0;
  assign not_full  = count_q < CW'(FIFO_DEPTH);
  assign do_pop    = pop_i && not_empty;
  assign do_push   = push_i && (not_full || do_pop);

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) begin
          mem_q[wr_ptr_q] <= entry_i;
          wr_ptr_q        <= wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
      end
    end
  end

  assign count_o = count_q;
  assign head_o  = not_empty ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC ownership, IMEM fetch, buffering to decode,
// redirect handling, end-of-program halt and sticky address fault.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_inst,
  output logic        halted,
  output logic        fault
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH) << 2;

  fetch_state_t  state_q;
  fetch_state_t  state_d;
  logic [31:0]   pc_q;
  logic [31:0]   pc_d;
  logic          push;
  logic          flush;
  logic          pop;
  logic          space;
  logic          pc_oob;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  new_entry;

  assign dec_valid = count != '0;
  assign pop       = dec_valid && dec_ready;
  assign space     = (count < CW'(FIFO_DEPTH)) || pop;
  assign pc_oob    = {1'b0, pc_q} >= PC_LIMIT;
  assign new_entry = '{pc: pc_q, inst: imem_inst};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (is_misaligned(redirect_target)) begin
            state_d = FAULT;
          end else begin
            pc_d = redirect_target;
          end
        end else if (pc_oob) begin
          flush   = 1'b1;
          state_d = FAULT;
        end else if (space && imem_inst == INST_NOP_END) begin
          state_d = HALT;
        end else if (space) begin
          push = 1'b1;
          pc_d = pc_q + 32'd4;
        end
      end
      HALT: begin
        // Only a redirect restarts fetch; the buffer keeps draining meanwhile.
        if (redirect_valid) begin
          flush = 1'b1;
          if (is_misaligned(redirect_target)) begin
            state_d = FAULT;
          end else begin
            state_d = RUN;
            pc_d    = redirect_target;
          end
        end
      end
      FAULT: begin
        flush = 1'b1;
      end
      default: begin
        flush   = 1'b1;
        state_d = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (push),
    .entry_i(new_entry),
    .pop_i  (pop),
    .flush_i(flush),
    .count_o(count),
    .head_o (head)
  );

  assign imem_pc  = pc_q;
  assign dec_pc   = head.pc;
  assign dec_inst = head.inst;
  assign halted   = state_q == HALT;
  assign fault    = state_q == FAULT;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomised and directed bench for ifetch_unit against a queue-based
// reference of the fetch rules.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic        halted;
  logic        fault;

  int checks = 0;
  int errors = 0;

  localparam int M_RUN = 0, M_HALT = 1, M_FAULT = 2;
  localparam int FD = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic [31:0] mem [256];
  ent_t        q [$];
  logic [31:0] m_pc;
  int          m_st;
  logic [31:0] prog [4];

  ifetch_unit #(
    .RESET_PC  (32'h0),
    .IMEM_DEPTH(256),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_inst       (dec_inst),
    .halted         (halted),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_read(input logic [31:0] a);
    if (a < 32'd1024) return mem[a[9:2]];
    return 32'h0;
  endfunction

  assign imem_inst = imem_read(imem_pc);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc = 32'h0;
    m_st = M_RUN;
  endtask

  // Applies the fetch rules for one clock edge using the pre-edge state.
  task automatic model_step();
    bit pop;
    bit space;
    logic [31:0] w;
    pop   = (q.size() != 0) && dec_ready;
    space = (q.size() < FD) || pop;
    w     = imem_read(m_pc);
    if (m_st == M_FAULT) return;
    if (redirect_valid) begin
      q.delete();
      if (redirect_target % 4 != 0) begin
        m_st = M_FAULT;
      end else begin
        m_pc = redirect_target;
        m_st = M_RUN;
      end
      return;
    end
    if (m_st == M_HALT) begin
      if (pop) void'(q.pop_front());
      return;
    end
    if (m_pc >= 32'd1024) begin
      q.delete();
      m_st = M_FAULT;
      return;
    end
    if (pop) void'(q.pop_front());
    if (space) begin
      if (w == 32'h0) begin
        m_st = M_HALT;
      end else begin
        q.push_back('{pc: m_pc, inst: w});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("dec_valid", 32'(dec_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("dec_pc", dec_pc, q[0].pc);
        chk("dec_inst", dec_inst, q[0].inst);
      end
      chk("halted", 32'(halted), 32'(m_st == M_HALT));
      chk("fault", 32'(fault), 32'(m_st == M_FAULT));
      chk("imem_pc", imem_pc, m_pc);
    end
  end

  task automatic step(input logic rdy, input logic rv, input logic [31:0] tgt);
    dec_ready       = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dec_ready = 1'b0;
    redirect_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(dec_valid), 32'h0);
    chk("rst_pc", imem_pc, 32'h0);
    rst = 1'b0;
  endtask

  task automatic load_base();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem[i] = prog[i];
  endtask

  initial begin
    prog[0] = 32'h003100B3;
    prog[1] = 32'h403100B3;
    prog[2] = 32'h00312023;
    prog[3] = 32'h00012083;
    load_base();
    model_reset();

    // Reset values and straight-line fetch to the halt word
    do_reset();
    chk("r_dec_pc", dec_pc, 32'h0);
    chk("r_dec_inst", dec_inst, 32'h0);
    chk("r_halted", 32'(halted), 32'h0);
    chk("r_fault", 32'(fault), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("s1_pc", dec_pc, 32'(i * 4));
      chk("s1_inst", dec_inst, prog[i]);
    end
    step(1'b1, 1'b0, 32'h0);
    chk("s1_halt", 32'(halted), 32'h1);
    chk("s1_drain", 32'(dec_valid), 32'h0);

    // Redirect while halted restarts from 0
    step(1'b1, 1'b1, 32'h0);
    chk("s4_run", 32'(halted), 32'h0);
    chk("s4_imem", imem_pc, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("s4_pc", dec_pc, 32'h0);

    // Backpressure
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
    chk("s2_hold", imem_pc, 32'h8);
    chk("s2_head", dec_pc, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("s2_next", dec_pc, 32'h4);
    step(1'b1, 1'b0, 32'h0);
    chk("s2_next2", dec_pc, 32'h8);

    // Redirect in the cycle 0x8 would be pushed
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h4);
    chk("s3_flush", 32'(dec_valid), 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("s3_pc", dec_pc, 32'h4);

    // Misaligned redirect
    step(1'b1, 1'b1, 32'h6);
    chk("s5_fault", 32'(fault), 32'h1);
    chk("s5_valid", 32'(dec_valid), 32'h0);
    step(1'b1, 1'b1, 32'h0);
    chk("s5_sticky", 32'(fault), 32'h1);

    // Out-of-range redirect
    do_reset();
    step(1'b1, 1'b1, 32'h400);
    chk("s5b_pre", 32'(fault), 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("s5b_fault", 32'(fault), 32'h1);
    step(1'b1, 1'b1, 32'h8);
    chk("s5b_sticky", 32'(fault), 32'h1);

    // Asynchronous reset with a full buffer
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("s6_full", 32'(dec_valid), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("s6_valid", 32'(dec_valid), 32'h0);
    chk("s6_imem", imem_pc, 32'h0);
    chk("s6_dpc", dec_pc, 32'h0);
    chk("s6_dinst", dec_inst, 32'h0);
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b0, 32'h0);
    chk("s6_after", dec_pc, 32'h0);

    // Randomised programs, backpressure and redirects
    for (int ep = 0; ep < 20; ep++) begin
      int len;
      len = $urandom_range(12, 1);
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      for (int i = 0; i < len; i++) mem[i] = $urandom | 32'h1;
      if (ep % 3 == 0) mem[255] = 32'hDEAD_BEEF;
      do_reset();
      for (int c = 0; c < 200; c++) begin
        logic rdy;
        logic rv;
        logic [31:0] tgt;
        int r;
        rdy = $urandom_range(99, 0) < 70;
        r   = $urandom_range(999, 0);
        rv  = r < 100;
        tgt = 32'(($urandom_range(len - 1, 0)) * 4);
        if (r < 5) tgt = 32'h400;
        else if (r < 10) tgt = 32'($urandom_range(len * 4, 0)) | 32'h1;
        else if (r < 20) tgt = 32'h3FC;
        step(rdy, rv, tgt);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
